lsu_byte_master: RTL and testbench

- Load/store initiator that sits between the CPU's MEM stage and the byte-addressed data memory.
- Accepts one load or store request of 1/2/4/8 bytes and serialises it into one byte access per cycle on a byte-wide memory port.
- Little-endian: lowest address holds bits [7:0].
- Assembles load data and sign- or zero-extends it to 64 bits, then returns a single-cycle response.

---
 rtl/lsu_byte_master_if.sv | 45 ++++
 rtl/lsu_byte_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_byte_master.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_byte_master_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_master_if
// Description : Request/response and byte-wide memory bus bundle for the
//               load/store byte master.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_byte_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // CPU-side request/response
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Byte-wide memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_master
// Description : Serialises 1/2/4/8-byte loads and stores into one byte access
//               per cycle, little-endian, with sign/zero-extended load data.
//               Optional macro LSU_MISALIGN_TRAP_EN traps misaligned requests.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_master #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    lsu_byte_master_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_cnt;

    logic              w_accept;
    logic              w_xfer;
    logic              w_resp;
    logic [2:0]        w_last_idx;
    logic              w_cnt_last;
    logic              w_sx;
    logic [DATA_W-1:0] w_ext;
    logic              w_misaligned;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_xfer   = (r_state == S_XFER);
    assign w_resp   = (r_state == S_RESP);

    always_comb begin
        w_last_idx = 3'd0;
        case (r_size)
            2'd0:    w_last_idx = 3'd0;
            2'd1:    w_last_idx = 3'd1;
            2'd2:    w_last_idx = 3'd3;
            default: w_last_idx = 3'd7;
        endcase
    end

    assign w_cnt_last = (r_cnt == w_last_idx);

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] w_align_mask;
    logic       r_err;

    always_comb begin
        w_align_mask = 3'b000;
        case (bus.req_size)
            2'd0:    w_align_mask = 3'b000;
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_misaligned = |(bus.req_addr[2:0] & w_align_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misaligned;
        end
    end

    assign bus.resp_err = w_resp & r_err;
`else
    assign w_misaligned = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misaligned ? S_RESP : S_XFER;
                end
            end
            S_XFER: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, byte counter and load-data assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= 3'd0;
        end else if (w_accept) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_size     <= bus.req_size;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_rdata    <= '0;
            r_cnt      <= 3'd0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 3'd1;
            if (!r_write) begin
                r_rdata[{r_cnt, 3'b000} +: 8] <= bus.mem_rdata;
            end
        end
    end

    // Doubles fill the whole word, so only narrower sizes are extended.
    assign w_sx = ~r_unsigned;

    always_comb begin
        w_ext = '0;
        case (r_size)
            2'd0:    w_ext = {{56{w_sx & r_rdata[7]}},  r_rdata[7:0]};
            2'd1:    w_ext = {{48{w_sx & r_rdata[15]}}, r_rdata[15:0]};
            2'd2:    w_ext = {{32{w_sx & r_rdata[31]}}, r_rdata[31:0]};
            default: w_ext = r_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from state so an async reset clears them at once
    // ------------------------------------------------------------------
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.mem_addr   = w_xfer ? (r_addr + ADDR_W'(r_cnt)) : '0;
    assign bus.mem_we     = w_xfer & r_write;
    assign bus.mem_re     = w_xfer & ~r_write;
    assign bus.mem_wdata  = (w_xfer && r_write) ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'h00;
    assign bus.resp_valid = w_resp;
    assign bus.resp_rdata = (w_resp && !r_write) ? w_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_master.sv
`default_nettype none
// Testbench for lsu_byte_master: directed table, hand-written corner sequences
// and randomized requests checked against a byte-array reference model.
module tb_lsu_byte_master;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_byte_master_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    lsu_byte_master #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory seen by the DUT (256 bytes, address aliased modulo 256)
    logic [7:0] mem [256];
    logic       preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h06;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    // Access monitor
    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t q_acc[$];
    acc_t mon_a;
    int   we_count   = 0;
    int   both_count = 0;

    always @(posedge clk) begin
        if (bus.mem_we || bus.mem_re) begin
            mon_a.we   = bus.mem_we;
            mon_a.addr = bus.mem_addr;
            mon_a.data = bus.mem_we ? bus.mem_wdata : bus.mem_rdata;
            q_acc.push_back(mon_a);
        end
        if (bus.mem_we) we_count++;
        if (bus.mem_we && bus.mem_re) both_count++;
    end

    // Reference model
    logic [7:0] ref_mem [256];

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] sz,
                                               input logic uns);
        int          n = 1 << sz;
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v |= 64'(ref_mem[8'(addr + 64'(k))]) << (8 * k);
        if (!uns && sz != 2'd3 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    function automatic bit model_trap(input logic [63:0] addr, input logic [1:0] sz);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % 64'(1 << sz)) != 64'd0;
`else
        return (addr[0] & 1'b0) != 1'b0 && sz == 2'd0;
`endif
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h required 0x%016h", name, act, exp);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    task automatic scramble_req();
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = {$urandom, $urandom};
        bus.req_wdata    = {$urandom, $urandom};
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    // One complete transaction with full checking
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] exp_rdata, input string tag);
        int n    = 1 << sz;
        bit trap = model_trap(addr, sz);
        int lat;
        int bad  = 0;
        drive_req(wr, sz, uns, addr, wd);
        wait_ready(tag);
        q_acc.delete();
        @(posedge clk); #1;
        scramble_req();
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), trap ? 64'd1 : 64'(n + 1));
        check({tag, " rdata"}, bus.resp_rdata, trap ? 64'd0 : exp_rdata);
        check({tag, " err"}, 64'(bus.resp_err), 64'(trap));
        check({tag, " strobes at resp"}, 64'({bus.mem_we, bus.mem_re}), 64'd0);
        check({tag, " access count"}, 64'(q_acc.size()), trap ? 64'd0 : 64'(n));
        for (int k = 0; k < q_acc.size(); k++) begin
            if (q_acc[k].addr !== addr + 64'(k)) bad++;
            if (q_acc[k].we !== wr) bad++;
            if (wr && q_acc[k].data !== wd[8*k +: 8]) bad++;
        end
        check({tag, " access detail errors"}, 64'(bad), 64'd0);
        if (wr && !trap)
            for (int k = 0; k < n; k++) ref_mem[8'(addr + 64'(k))] = wd[8*k +: 8];
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp;
    } vec_t;

    vec_t        vt [10];
    logic [63:0] old_val;
    logic [63:0] got_val;
    int          wc0;
    int          cyc;
    int          resp_at;

    initial begin
        vt[0] = '{1'b0, 2'd3, 1'b0, 64'd0,    64'd0,           64'h0000_0000_0000_0006};
        vt[1] = '{1'b1, 2'd0, 1'b0, 64'd3,    64'h0000_00AB,   64'd0};
        vt[2] = '{1'b0, 2'd0, 1'b0, 64'd3,    64'd0,           64'hFFFF_FFFF_FFFF_FFAB};
        vt[3] = '{1'b0, 2'd0, 1'b1, 64'd3,    64'd0,           64'h0000_0000_0000_00AB};
        vt[4] = '{1'b1, 2'd2, 1'b0, 64'd16,   64'h8000_0001,   64'd0};
        vt[5] = '{1'b0, 2'd2, 1'b0, 64'd16,   64'd0,           64'hFFFF_FFFF_8000_0001};
        vt[6] = '{1'b0, 2'd2, 1'b1, 64'd16,   64'd0,           64'h0000_0000_8000_0001};
        vt[7] = '{1'b1, 2'd1, 1'b0, 64'h20,   64'h0000_F234,   64'd0};
        vt[8] = '{1'b0, 2'd1, 1'b0, 64'h20,   64'd0,           64'hFFFF_FFFF_FFFF_F234};
        vt[9] = '{1'b0, 2'd2, 1'b0, 64'd2,    64'd0,           64'h0000_0000_0000_AB00};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h06;
        preload = 1'b1;
        scramble_req();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("reset mem strobes", 64'({bus.mem_we, bus.mem_re}), 64'd0);
        check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        check("reset resp_rdata", bus.resp_rdata, 64'd0);
        check("reset mem_addr", bus.mem_addr, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready after reset", 64'(bus.req_ready), 64'd1);

        // Directed table
        for (int i = 0; i < 10; i++)
            run_req(vt[i].wr, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, vt[i].exp,
                    $sformatf("vec%0d", i));

        // Second request held valid during a double store
        drive_req(1'b1, 2'd3, 1'b0, 64'h40, 64'h0123_4567_89AB_CDEF);
        wait_ready("hold");
        wc0 = we_count;
        @(posedge clk); #1;
        drive_req(1'b1, 2'd0, 1'b0, 64'h50, 64'h0000_005A);
        cyc     = 0;
        resp_at = 0;
        while (!bus.req_ready && cyc < 30) begin
            if (bus.resp_valid) resp_at = cyc + 1;
            cyc++;
            @(posedge clk); #1;
        end
        check("hold busy cycles", 64'(cyc), 64'd9);
        check("hold first resp cycle", 64'(resp_at), 64'd9);
        @(posedge clk); #1;
        scramble_req();
        @(posedge clk); #1;
        check("hold second resp", 64'(bus.resp_valid), 64'd1);
        @(posedge clk); #1;
        check("hold we pulses", 64'(we_count - wc0), 64'd9);
        for (int k = 0; k < 8; k++) got_val[8*k +: 8] = mem[8'h40 + 8'(k)];
        check("hold double bytes", got_val, 64'h0123_4567_89AB_CDEF);
        check("hold byte", 64'(mem[8'h50]), 64'h5A);
        for (int k = 0; k < 8; k++) ref_mem[8'h40 + 8'(k)] = got_val[8*k +: 8];
        ref_mem[8'h50] = 8'h5A;

        // Reset in the middle of a double store to address 8
        for (int k = 0; k < 8; k++) old_val[8*k +: 8] = mem[8 + k];
        drive_req(1'b1, 2'd3, 1'b0, 64'd8, 64'h1122_3344_5566_7788);
        wait_ready("abort");
        wc0 = we_count;
        @(posedge clk); #1;
        scramble_req();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort strobes", 64'({bus.mem_we, bus.mem_re}), 64'd0);
        check("abort mem_addr", bus.mem_addr, 64'd0);
        check("abort mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("abort resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort ready after release", 64'(bus.req_ready), 64'd1);
        check("abort we pulses", 64'(we_count - wc0), 64'd3);
        for (int k = 0; k < 8; k++) got_val[8*k +: 8] = mem[8 + k];
        check("abort bytes 8..15", got_val, {old_val[63:24], 24'h667788});
        ref_mem[8]  = 8'h88;
        ref_mem[9]  = 8'h77;
        ref_mem[10] = 8'h66;

        // Randomized requests against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        r_wr;
            logic [1:0]  r_sz;
            logic        r_uns;
            logic [63:0] r_addr;
            logic [63:0] r_wd;
            r_wr   = 1'($urandom);
            r_sz   = 2'($urandom);
            r_uns  = 1'($urandom);
            r_addr = ($urandom_range(0, 3) == 0) ? {56'hFF_FFFF_FFFF_FFFF, 8'($urandom)}
                                                  : 64'($urandom_range(0, 255));
            r_wd   = {$urandom, $urandom};
            run_req(r_wr, r_sz, r_uns, r_addr, r_wd,
                    r_wr ? 64'd0 : model_load(r_addr, r_sz, r_uns),
                    $sformatf("rnd%0d", i));
        end

        check("we and re never together", 64'(both_count), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
